// File: rtl/instr_mem_resp64.sv
// rtl/instr_mem_resp64.sv - instruction fetch responder with loadable doubleword memory
module instr_mem_resp64 #(
  parameter int unsigned MemDepth = 1024,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned Latency  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [63:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        stall_i,
  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  input  logic [63:0] ld_wdata_i,
  input  logic [7:0]  ld_be_i,
  output logic        ld_gnt_o,
  output logic        ld_err_o
);

  localparam int unsigned IdxW = (MemDepth > 1) ? $clog2(MemDepth) : 1;

  logic [63:0]     mem [MemDepth];

  logic [31:0]     fetch_off;
  logic [31:0]     ld_off;
  logic            fetch_in_range;
  logic            ld_in_range;
  logic [IdxW-1:0] fetch_idx;
  logic [IdxW-1:0] ld_idx;
  logic [63:0]     fetch_rdata;

  logic [Latency-1:0] pipe_valid;
  logic [Latency-1:0] pipe_err;
  logic [63:0]        pipe_data [Latency];

  // The byte offset within a doubleword is irrelevant: the whole aligned word
  // is returned and the prefetch buffer picks the halfwords it needs.
  logic unused_byte_offset;
  assign unused_byte_offset = ^{fetch_off[2:0], ld_off[2:0]};

  // Offsets are unsigned, so addresses below BaseAddr wrap to huge values
  // and fall out of range naturally.
  assign fetch_off      = instr_addr_i - BaseAddr;
  assign ld_off         = ld_addr_i - BaseAddr;
  assign fetch_in_range = {3'b000, fetch_off[31:3]} < MemDepth;
  assign ld_in_range    = {3'b000, ld_off[31:3]} < MemDepth;
  assign fetch_idx      = fetch_off[3 +: IdxW];
  assign ld_idx         = ld_off[3 +: IdxW];

  // Loads always win the memory; a fetch colliding with a load retries later.
  assign ld_gnt_o    = ld_req_i;
  assign ld_err_o    = ld_req_i & ~ld_in_range;
  assign instr_gnt_o = instr_req_i & ~ld_req_i & ~stall_i;

  // Error and idle slots carry zero data so the response bus never leaks memory.
  assign fetch_rdata = (instr_gnt_o && fetch_in_range) ? mem[fetch_idx] : 64'h0;

  // Byte-masked program load; out-of-range loads are dropped, memory is never reset.
  always_ff @(posedge clk_i) begin
    if (ld_req_i && ld_in_range) begin
      for (int k = 0; k < 8; k++) begin
        if (ld_be_i[k]) begin
          mem[ld_idx][8*k +: 8] <= ld_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Fixed-depth response pipeline: stage 0 captures the grant-cycle read, the
  // rest only delay it, so responses leave in grant order with no back-pressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < int'(Latency); i++) begin
        pipe_data[i] <= 64'h0;
      end
    end else begin
      pipe_valid[0] <= instr_gnt_o;
      pipe_err[0]   <= instr_gnt_o & ~fetch_in_range;
      pipe_data[0]  <= fetch_rdata;
      for (int i = 1; i < int'(Latency); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign instr_rvalid_o = pipe_valid[Latency-1];
  assign instr_err_o    = pipe_err[Latency-1];
  assign instr_rdata_o  = pipe_data[Latency-1];

endmodule

// File: tb/tb_instr_mem_resp64.sv
// tb/tb_instr_mem_resp64.sv - directed self-checking bench for instr_mem_resp64
module tb_instr_mem_resp64;

  logic        clk;
  logic [2:0]  rst_n, req, stall, ld_req;
  logic [2:0]  gnt, rvalid, err, ld_gnt, ld_err;
  logic [31:0] addr [3];
  logic [31:0] ld_addr [3];
  logic [63:0] wdata [3];
  logic [7:0]  be [3];
  logic [63:0] rdata [3];

  int n_chk;
  int n_fail;

  // Instance 0: Latency 1, instance 1: Latency 3, instance 2: Latency 4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_mem_resp64 #(
      .MemDepth(16),
      .BaseAddr(32'h0000_2000),
      .Latency ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n[g]),
      .instr_req_i   (req[g]),
      .instr_addr_i  (addr[g]),
      .instr_gnt_o   (gnt[g]),
      .instr_rvalid_o(rvalid[g]),
      .instr_rdata_o (rdata[g]),
      .instr_err_o   (err[g]),
      .stall_i       (stall[g]),
      .ld_req_i      (ld_req[g]),
      .ld_addr_i     (ld_addr[g]),
      .ld_wdata_i    (wdata[g]),
      .ld_be_i       (be[g]),
      .ld_gnt_o      (ld_gnt[g]),
      .ld_err_o      (ld_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [31:0] la;
    logic [63:0] wd;
    logic [7:0]  be;
    logic        req;
    logic [31:0] fa;
    logic        stall;
    logic        e_gnt;
    logic        e_lgnt;
    logic        e_lerr;
    logic        e_rv;
    logic        e_err;
    logic [63:0] e_rd;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i);
    req[i] = 1'b0; stall[i] = 1'b0; ld_req[i] = 1'b0;
    addr[i] = 32'h0; ld_addr[i] = 32'h0; wdata[i] = 64'h0; be[i] = 8'h0;
  endtask

  task automatic do_load(input int i, input logic [31:0] a, input logic [63:0] d);
    idle(i);
    ld_req[i] = 1'b1; ld_addr[i] = a; wdata[i] = d; be[i] = 8'hFF;
    next_cycle();
    idle(i);
  endtask

  function automatic logic [63:0] stream_word(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;

    // Load/fetch sequence on the Latency-1 instance; each row is one cycle and
    // its expectations are the outputs observed within that same cycle.
    tv[0]  = '{1'b1, 32'h2000, 64'h1111_2222_3333_4444, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    tv[1]  = '{1'b1, 32'h2078, 64'h5555_6666_7777_8888, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    tv[2]  = '{1'b1, 32'h2008, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    tv[3]  = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h2004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    tv[4]  = '{1'b1, 32'h2008, 64'h0102_0304_0506_0708, 8'h0F, 1'b1, 32'h2008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1111_2222_3333_4444};
    tv[5]  = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h200C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    tv[6]  = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h2080, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hAAAA_BBBB_0506_0708};
    tv[7]  = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h1FF8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0};
    tv[8]  = '{1'b1, 32'h2080, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0};
    tv[9]  = '{1'b1, 32'h1FF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0};
    tv[10] = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    tv[11] = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h207F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1111_2222_3333_4444};
    tv[12] = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h5555_6666_7777_8888};
    tv[13] = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    tv[14] = '{1'b1, 32'h2000, 64'h0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
    tv[15] = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    tv[16] = '{1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1111_2222_3333_4444};

    rst_n = 3'b000;
    for (int i = 0; i < 3; i++) idle(i);
    next_cycle();
    #3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_rvalid[%0d]", i), 64'(rvalid[i]), 64'h0);
      chk($sformatf("reset_rdata[%0d]", i), rdata[i], 64'h0);
      chk($sformatf("reset_err[%0d]", i), 64'(err[i]), 64'h0);
      chk($sformatf("reset_gnt[%0d]", i), 64'(gnt[i]), 64'h0);
      chk($sformatf("reset_ld_gnt[%0d]", i), 64'(ld_gnt[i]), 64'h0);
      chk($sformatf("reset_ld_err[%0d]", i), 64'(ld_err[i]), 64'h0);
    end
    next_cycle();
    rst_n = 3'b111;
    #3;
    chk("post_reset_rvalid", 64'(rvalid), 64'h0);
    next_cycle();

    for (int v = 0; v < 17; v++) begin
      ld_req[0] = tv[v].ld;  ld_addr[0] = tv[v].la; wdata[0] = tv[v].wd; be[0] = tv[v].be;
      req[0]    = tv[v].req; addr[0]    = tv[v].fa; stall[0] = tv[v].stall;
      #3;
      chk($sformatf("v%0d_gnt", v), 64'(gnt[0]), 64'(tv[v].e_gnt));
      chk($sformatf("v%0d_ld_gnt", v), 64'(ld_gnt[0]), 64'(tv[v].e_lgnt));
      chk($sformatf("v%0d_ld_err", v), 64'(ld_err[0]), 64'(tv[v].e_lerr));
      chk($sformatf("v%0d_rvalid", v), 64'(rvalid[0]), 64'(tv[v].e_rv));
      if (tv[v].e_rv) begin
        chk($sformatf("v%0d_err", v), 64'(err[0]), 64'(tv[v].e_err));
        chk($sformatf("v%0d_rdata", v), rdata[0], tv[v].e_rd);
      end
      next_cycle();
    end
    idle(0);

    // Streaming on the Latency-3 instance: 8 held requests, 8 contiguous responses.
    for (int i = 0; i < 8; i++) do_load(1, 32'h2000 + 32'(8*i), stream_word(i));
    for (int c = 0; c < 12; c++) begin
      req[1]  = (c < 8);
      addr[1] = 32'h2000 + 32'(8*c);
      #3;
      chk($sformatf("stream_c%0d_gnt", c), 64'(gnt[1]), 64'(c < 8));
      chk($sformatf("stream_c%0d_rvalid", c), 64'(rvalid[1]), 64'(c >= 3 && c < 11));
      if (c >= 3 && c < 11) begin
        chk($sformatf("stream_c%0d_rdata", c), rdata[1], stream_word(c - 3));
        chk($sformatf("stream_c%0d_err", c), 64'(err[1]), 64'h0);
      end
      next_cycle();
    end
    idle(1);

    // Stall for 5 cycles while the address wanders; the grant-cycle address wins.
    for (int c = 0; c < 9; c++) begin
      req[1]   = (c <= 5);
      stall[1] = (c < 5);
      addr[1]  = 32'h2000 + 32'(8*c);
      #3;
      chk($sformatf("stall_c%0d_gnt", c), 64'(gnt[1]), 64'(c == 5));
      chk($sformatf("stall_c%0d_rvalid", c), 64'(rvalid[1]), 64'(c == 8));
      if (c == 8) chk("stall_rdata", rdata[1], stream_word(5));
      next_cycle();
    end
    idle(1);

    // Reset mid-flight on the Latency-4 instance.
    for (int i = 0; i < 3; i++) do_load(2, 32'h2000 + 32'(8*i), 64'hBEEF_0000_0000_0000 + 64'(i));
    for (int c = 0; c < 5; c++) begin
      req[2]  = (c < 3);
      addr[2] = 32'h2000 + 32'(8*c);
      #3;
      chk($sformatf("rst_c%0d_gnt", c), 64'(gnt[2]), 64'(c < 3));
      chk($sformatf("rst_c%0d_rvalid", c), 64'(rvalid[2]), 64'(c == 4));
      if (c == 4) chk("rst_first_rdata", rdata[2], 64'hBEEF_0000_0000_0000);
      next_cycle();
    end
    idle(2);
    chk("rst_rvalid_before_reset", 64'(rvalid[2]), 64'h1);
    rst_n[2] = 1'b0;
    #1;
    chk("rst_rvalid_async_drop", 64'(rvalid[2]), 64'h0);
    chk("rst_rdata_async_clear", rdata[2], 64'h0);
    next_cycle();
    chk("rst_rvalid_held", 64'(rvalid[2]), 64'h0);
    next_cycle();
    rst_n[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #3;
      chk($sformatf("rst_stale_c%0d_rvalid", c), 64'(rvalid[2]), 64'h0);
      next_cycle();
    end
    for (int c = 0; c < 5; c++) begin
      req[2]  = (c == 0);
      addr[2] = 32'h2010;
      #3;
      if (c == 0) chk("rst_refetch_gnt", 64'(gnt[2]), 64'h1);
      chk($sformatf("rst_refetch_c%0d_rvalid", c), 64'(rvalid[2]), 64'(c == 4));
      if (c == 4) chk("rst_refetch_rdata", rdata[2], 64'hBEEF_0000_0000_0002);
      next_cycle();
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_resp64.md
# instr_mem_resp64

Responder end of the 64-bit instruction fetch interface driven by the fetch stage's prefetch buffer. It owns a dual-use doubleword instruction memory. It grants fetch requests, returns the aligned 64-bit doubleword a fixed number of cycles later, and flags out-of-range fetches with an error. A load port writes program images into the same memory; a load takes priority over fetch in any cycle both are requested.

## Interface
Parameters:
- `MemDepth`, 1024: memory size in 64-bit doublewords; power of two.
- `BaseAddr`, 32'h0000_0000: byte address of doubleword 0; aligned to `MemDepth*8`.
- `Latency`, 1: cycles from grant to `instr_rvalid_o`; legal range 1..4.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.

Fetch port:
- `instr_req_i`  in  1  fetch request.
- `instr_addr_i`  in  32  fetch byte address.
- `instr_gnt_o`  out  1  request accepted this cycle.
- `instr_rvalid_o`  out  1  response valid.
- `instr_rdata_o`  out  64  doubleword; byte 0 in bits [7:0].
- `instr_err_o`  out  1  response is a fetch error; qualified by `instr_rvalid_o`.

Other:
- `stall_i`  in  1  test/arbiter hook; blocks fetch grants.
- `ld_req_i`  in  1  load write request.
- `ld_addr_i`  in  32  load byte address.
- `ld_wdata_i`  in  64  load data.
- `ld_be_i`  in  8  load byte enables.
- `ld_gnt_o`  out  1  load accepted.
- `ld_err_o`  out  1  load address out of range; write dropped.

## Operation
- **Range check:** an address is in range iff `(addr - BaseAddr) >> 3 < MemDepth`, computed as unsigned 32-bit. Index = `(addr - BaseAddr)[3+:log2(MemDepth)]`. `addr[2:0]` is ignored; the aligned doubleword is always returned and the prefetch buffer selects halfwords.
- **Fetch grant:** `instr_gnt_o = instr_req_i & ~ld_req_i & ~stall_i`, combinational.
  - No limit on outstanding requests; the pipeline depth equals `Latency`, so a grant is possible every cycle.
- **Load:** `ld_gnt_o = ld_req_i`, combinational.
  - In range: bytes with `ld_be_i[k]=1` are written at the clock edge.
  - Out of range: `ld_err_o=1` in the same cycle and memory is unchanged.
- **Fetch read:** on a granted fetch, the memory is read in the grant cycle. The data is captured into pipeline stage 0 at the edge, together with valid=1 and err=!in_range.
  - Error responses carry `rdata=0`.
  - Stages 1..`Latency`-1 are plain registers. The output is the last stage.
- **Write/read ordering:** a fetch granted in cycle N sees every load written at edges before N. A load in cycle N blocks the fetch in N. A load after the grant does not alter an in-flight response.
- **Response order:** responses are returned strictly in grant order. There is no back-pressure: the initiator must accept `instr_rvalid_o` every cycle it is high.
- **Reset:** all pipeline stages clear valid/err/data. Outstanding fetches are discarded with no response. Memory contents are not reset. Combinational outputs follow their inputs.

## Timing
- **Reset values:** `instr_rvalid_o=0`, `instr_rdata_o=0`, `instr_err_o=0`. `instr_gnt_o`, `ld_gnt_o` and `ld_err_o` are combinational and equal 0 when their request is 0.
- **Latency:** grant in cycle N gives `instr_rvalid_o=1` in cycle N+`Latency`, for exactly one cycle per grant.
- **Back-to-back grants** in N..N+k give rvalid in N+L..N+L+k, with no gaps.
- **Simultaneous load and fetch:** the load is accepted, the fetch is not granted, and the fetch retries the next cycle.
- **Request held across stall:** the address may change while ungranted; the address sampled is the one in the grant cycle.
- **Reset asserted mid-flight:** `instr_rvalid_o` falls asynchronously. No stale response appears after `rst_ni` rises.
- **Wrap-around:** `addr < BaseAddr` underflows to a large value, fails the range check, and produces an error response.

## Test plan
- **Load then fetch**, `Latency=1`: load `0x1111_2222_3333_4444` at `BaseAddr`, then fetch `BaseAddr+4` -> gnt in the same cycle; one cycle later rvalid=1, rdata=`0x1111_2222_3333_4444`, err=0.
- **Streaming**, `Latency=3`: 8 consecutive fetches of doublewords 0..7 with req held -> 8 contiguous grants, then 8 contiguous rvalids starting 3 cycles after the first grant, with data in order.
- **Collision:** `ld_req_i` and `instr_req_i` both high in cycle N to the same index -> `ld_gnt_o=1`, `instr_gnt_o=0`. The fetch is granted in N+1 and returns the new data. A byte-enable-masked load `ld_be_i=8'h0F` changes only the low 4 bytes.
- **Range errors:** fetch `BaseAddr+MemDepth*8` and `BaseAddr-8` -> both granted; rvalid with err=1, rdata=0. A load to the same addresses gives `ld_err_o=1` and memory is unchanged.
- **Stall:** `stall_i=1` for 5 cycles with req high -> no gnt and no rvalid. Grant occurs on the first cycle `stall_i=0`.
- **Reset mid-flight**, `Latency=4`: 3 grants, then `rst_ni` low for 2 cycles -> rvalid=0 immediately. No responses appear after release. A new fetch then returns correctly.
